// File: rtl/ex_muldiv_unit_if.sv
// Handshake bundle between the ID/EX register and the EX-stage multiply/divide unit.
// The master side presents the decoded op and forwarded operands. The slave side
// returns HI/LO, the MF read data and the stall/status flags.
interface ex_muldiv_unit_if;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        kill;
    logic [31:0] rdata;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        stall_req;
    logic        done;

    modport master (
        output op, a, b, kill,
        input  rdata, hi, lo, busy, stall_req, done
    );

    modport slave (
        input  op, a, b, kill,
        output rdata, hi, lo, busy, stall_req, done
    );
endinterface

// File: rtl/ex_muldiv_unit.sv
// Iterative 32-bit multiply/divide unit with architectural HI/LO registers.
// Multiplies use shift-add and divides use restoring division, each over 32 iterations
// on operand magnitudes. The result sign is applied in a final FIX cycle.
// MTHI/MTLO write in one cycle, and MFHI/MFLO read combinationally.
module ex_muldiv_unit (
    input  logic            clk,
    input  logic            reset,
    ex_muldiv_unit_if.slave bus
);
    localparam int DATA_W = 32;

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MFHI  = 4'd7;
    localparam logic [3:0] OP_MFLO  = 4'd8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t                state;
    logic [4:0]            cnt;
    // Multiply: {partial product high, product bits shifted in}.
    // Divide: {remainder, quotient}.
    logic [2*DATA_W-1:0]   acc;
    // Multiply: multiplicand. Divide: dividend, shifted left one bit per step.
    logic [DATA_W-1:0]     opnd_a;
    // Multiply: multiplier, shifted right one bit per step. Divide: divisor.
    logic [DATA_W-1:0]     opnd_b;
    logic                  is_div;
    logic                  neg_q;    // negate product / quotient in FIX
    logic                  neg_r;    // negate remainder in FIX
    logic [DATA_W-1:0]     hi_reg;
    logic [DATA_W-1:0]     lo_reg;
    logic                  done_reg;

    logic                  is_start;
    logic                  op_signed;
    logic                  op_is_div;
    logic [DATA_W:0]       mul_sum;
    logic [2*DATA_W-1:0]   mul_next;
    logic [DATA_W:0]       div_shift;
    logic [DATA_W:0]       div_diff;
    logic [2*DATA_W-1:0]   div_next;
    logic [2*DATA_W-1:0]   prod_fixed;
    logic [DATA_W-1:0]     quot_fixed;
    logic [DATA_W-1:0]     rem_fixed;

    // Unsigned magnitude of an operand. Signed ops take the two's complement of negatives.
    // 0x80000000 maps to itself, which is the correct unsigned magnitude.
    function automatic logic [DATA_W-1:0] magnitude(input logic [DATA_W-1:0] v,
                                                    input logic is_signed);
        logic signed [DATA_W-1:0] sv;
        sv = v;
        return (is_signed && (sv < 0)) ? (~v + 1'b1) : v;
    endfunction

    // Conditional 32-bit two's complement negation.
    function automatic logic [DATA_W-1:0] neg_if32(input logic [DATA_W-1:0] v,
                                                   input logic en);
        return en ? (~v + 1'b1) : v;
    endfunction

    // Conditional 64-bit two's complement negation.
    function automatic logic [2*DATA_W-1:0] neg_if64(input logic [2*DATA_W-1:0] v,
                                                     input logic en);
        return en ? (~v + 1'b1) : v;
    endfunction

    assign is_start  = (bus.op == OP_MULT) || (bus.op == OP_MULTU) ||
                       (bus.op == OP_DIV)  || (bus.op == OP_DIVU);
    assign op_signed = (bus.op == OP_MULT) || (bus.op == OP_DIV);
    assign op_is_div = (bus.op == OP_DIV)  || (bus.op == OP_DIVU);

    // One shift-add multiply step: add the multiplicand into the top half
    // (33 bits, carry kept), then shift the whole accumulator right by one.
    always_comb begin
        mul_sum = {1'b0, acc[2*DATA_W-1:DATA_W]};
        if (opnd_b[0]) begin
            mul_sum = mul_sum + {1'b0, opnd_a};
        end
        mul_next = {mul_sum, acc[DATA_W-1:1]};
    end

    // One restoring divide step. Shift the next dividend bit into the remainder,
    // trial-subtract the divisor, and keep the difference only when it is non-negative.
    // The remainder stays below the divisor, so a 33-bit subtract is sufficient.
    always_comb begin
        div_shift = {acc[2*DATA_W-1:DATA_W], opnd_a[DATA_W-1]};
        div_diff  = div_shift - {1'b0, opnd_b};
        if (!div_diff[DATA_W]) begin
            div_next = {div_diff[DATA_W-1:0], acc[DATA_W-2:0], 1'b1};
        end else begin
            div_next = {div_shift[DATA_W-1:0], acc[DATA_W-2:0], 1'b0};
        end
    end

    assign prod_fixed = neg_if64(acc, neg_q);
    assign quot_fixed = neg_if32(acc[DATA_W-1:0], neg_q);
    assign rem_fixed  = neg_if32(acc[2*DATA_W-1:DATA_W], neg_r);

    assign bus.busy      = (state != IDLE);
    assign bus.stall_req = bus.busy && (bus.op >= OP_MULT) && (bus.op <= OP_MFLO);
    assign bus.rdata     = (bus.op == OP_MFHI) ? hi_reg :
                           (bus.op == OP_MFLO) ? lo_reg : '0;
    assign bus.hi        = hi_reg;
    assign bus.lo        = lo_reg;
    assign bus.done      = done_reg;

    // Control FSM and datapath registers.
    // A kill drops back to IDLE without touching HI/LO. It also wins over the
    // last-iteration transition into FIX.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            cnt      <= '0;
            acc      <= '0;
            opnd_a   <= '0;
            opnd_b   <= '0;
            is_div   <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            hi_reg   <= '0;
            lo_reg   <= '0;
            done_reg <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state)
                IDLE: begin
                    if (!bus.kill) begin
                        if (is_start) begin
                            opnd_a <= magnitude(bus.a, op_signed);
                            opnd_b <= magnitude(bus.b, op_signed);
                            is_div <= op_is_div;
                            neg_q  <= op_signed && (bus.a[DATA_W-1] ^ bus.b[DATA_W-1]);
                            neg_r  <= op_signed && op_is_div && bus.a[DATA_W-1];
                            acc    <= '0;
                            cnt    <= '0;
                            state  <= CALC;
                        end else if (bus.op == OP_MTHI) begin
                            hi_reg <= bus.a;
                        end else if (bus.op == OP_MTLO) begin
                            lo_reg <= bus.a;
                        end
                    end
                end
                CALC: begin
                    if (bus.kill) begin
                        state <= IDLE;
                    end else begin
                        if (is_div) begin
                            acc    <= div_next;
                            opnd_a <= opnd_a << 1;
                        end else begin
                            acc    <= mul_next;
                            opnd_b <= opnd_b >> 1;
                        end
                        cnt <= cnt + 5'd1;
                        if (cnt == 5'd31) begin
                            state <= FIX;
                        end
                    end
                end
                FIX: begin
                    if (!bus.kill) begin
                        if (is_div) begin
                            lo_reg <= quot_fixed;
                            hi_reg <= rem_fixed;
                        end else begin
                            hi_reg <= prod_fixed[2*DATA_W-1:DATA_W];
                            lo_reg <= prod_fixed[DATA_W-1:0];
                        end
                        done_reg <= 1'b1;
                    end
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit. A behavioural model computes results with
// plain arithmetic and models busy time as a countdown. One process compares the DUT
// against the model on every falling edge. Directed cases pin the model with literal
// values, and a random phase follows.
module tb_ex_muldiv_unit;
    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    ex_muldiv_unit_if bus();

    ex_muldiv_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int          n_assert = 0;
    int          n_fail   = 0;

    // Behavioural model state.
    int          m_left = 0;        // cycles until the pending result lands
    logic [31:0] m_hi   = '0;
    logic [31:0] m_lo   = '0;
    logic [31:0] p_hi   = '0;
    logic [31:0] p_lo   = '0;
    logic        m_done = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural result {HI, LO} of a mul/div op.
    function automatic logic [63:0] ref_result(input logic [3:0] o, input logic [31:0] x,
                                               input logic [31:0] y);
        longint      sx;
        longint      sy;
        logic [63:0] p;
        logic [31:0] mx;
        logic [31:0] my;
        logic [31:0] q;
        logic [31:0] r;
        p = '0;
        if (o == 4'd1) begin
            sx = longint'($signed(x));
            sy = longint'($signed(y));
            p  = 64'(sx * sy);
        end else if (o == 4'd2) begin
            p = {32'd0, x} * {32'd0, y};
        end else begin
            mx = (o == 4'd3 && x[31]) ? (32'd0 - x) : x;
            my = (o == 4'd3 && y[31]) ? (32'd0 - y) : y;
            if (my == 32'd0) begin
                q = '1;
                r = mx;
            end else begin
                q = mx / my;
                r = mx % my;
            end
            if (o == 4'd3 && (x[31] ^ y[31])) q = 32'd0 - q;
            if (o == 4'd3 && x[31])           r = 32'd0 - r;
            p = {r, q};
        end
        return p;
    endfunction

    // Model update on each rising edge.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_left <= 0;
            m_hi   <= '0;
            m_lo   <= '0;
            m_done <= 1'b0;
        end else begin
            m_done <= 1'b0;
            if (m_left != 0) begin
                if (bus.kill) begin
                    m_left <= 0;
                end else begin
                    m_left <= m_left - 1;
                    if (m_left == 1) begin
                        m_hi   <= p_hi;
                        m_lo   <= p_lo;
                        m_done <= 1'b1;
                    end
                end
            end else if (!bus.kill) begin
                if (bus.op >= 4'd1 && bus.op <= 4'd4) begin
                    {p_hi, p_lo} <= ref_result(bus.op, bus.a, bus.b);
                    m_left       <= 33;
                end else if (bus.op == 4'd5) begin
                    m_hi <= bus.a;
                end else if (bus.op == 4'd6) begin
                    m_lo <= bus.a;
                end
            end
        end
    end

    // Compare DUT against the model away from the active edge.
    always @(negedge clk) begin
        chk("busy", 32'(bus.busy), 32'(m_left != 0));
        chk("stall_req", 32'(bus.stall_req),
            32'((m_left != 0) && bus.op >= 4'd1 && bus.op <= 4'd8));
        chk("done", 32'(bus.done), 32'(m_done));
        chk("hi", bus.hi, m_hi);
        chk("lo", bus.lo, m_lo);
        chk("rdata", bus.rdata,
            (bus.op == 4'd7) ? m_hi : (bus.op == 4'd8) ? m_lo : 32'd0);
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
            #1;
        end
    endtask

    // Present an op like ID/EX does: hold it while stalled, and return after the accepting edge.
    task automatic present(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
        int guard;
        guard  = 0;
        bus.op = o;
        bus.a  = x;
        bus.b  = y;
        #1;
        while (bus.stall_req === 1'b1 && guard < 200) begin
            @(posedge clk);
            @(negedge clk);
            #1;
            guard++;
        end
        chk("accept_timeout", 32'(guard >= 200), 32'd0);
        @(posedge clk);
        @(negedge clk);
        #1;
        bus.op = 4'd0;
    endtask

    // Wait for done after an accepted start. The result must land 33 edges after acceptance.
    task automatic wait_done();
        int cycles;
        cycles = 0;
        while (bus.done !== 1'b1 && cycles < 100) begin
            @(posedge clk);
            @(negedge clk);
            #1;
            cycles++;
        end
        chk("done_latency", cycles, 32'd33);
        chk("busy_at_done", 32'(bus.busy), 32'd0);
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 6))
            0:       return 32'h0000_0000;
            1:       return 32'h0000_0001;
            2:       return 32'h8000_0000;
            3:       return 32'hFFFF_FFFF;
            default: return $urandom();
        endcase
    endfunction

    initial begin
        int          stalls;
        logic        seen;
        logic [3:0]  o;
        logic [31:0] x;
        logic [31:0] y;
        int          k;

        bus.op   = 4'd0;
        bus.a    = '0;
        bus.b    = '0;
        bus.kill = 1'b0;
        reset    = 1'b1;
        #2 reset = 1'b0;
        @(negedge clk);
        #1;
        bus.op = 4'd7;
        #1;
        chk("reset_busy", 32'(bus.busy), 32'd0);
        chk("reset_stall", 32'(bus.stall_req), 32'd0);
        chk("reset_done", 32'(bus.done), 32'd0);
        chk("reset_hi", bus.hi, 32'd0);
        chk("reset_lo", bus.lo, 32'd0);
        chk("reset_rdata", bus.rdata, 32'd0);
        bus.op = 4'd0;
        @(negedge clk);
        #1;
        reset = 1'b1;
        idle(1);

        // Signed and unsigned arithmetic, including the boundary operands
        present(4'd1, 32'd7, 32'hFFFF_FFFD);
        wait_done();
        chk("mult_7_m3_hi", bus.hi, 32'hFFFF_FFFF);
        chk("mult_7_m3_lo", bus.lo, 32'hFFFF_FFEB);

        present(4'd1, 32'h8000_0000, 32'h8000_0000);
        wait_done();
        chk("mult_min_hi", bus.hi, 32'h4000_0000);
        chk("mult_min_lo", bus.lo, 32'h0000_0000);

        present(4'd4, 32'd100, 32'd7);
        wait_done();
        chk("divu_100_7_lo", bus.lo, 32'h0000_000E);
        chk("divu_100_7_hi", bus.hi, 32'h0000_0002);

        present(4'd3, 32'hFFFF_FFF9, 32'd2);
        wait_done();
        chk("div_m7_2_lo", bus.lo, 32'hFFFF_FFFD);
        chk("div_m7_2_hi", bus.hi, 32'hFFFF_FFFF);

        present(4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done();
        chk("div_ovf_lo", bus.lo, 32'h8000_0000);
        chk("div_ovf_hi", bus.hi, 32'h0000_0000);

        present(4'd4, 32'd5, 32'd0);
        wait_done();
        chk("divu_by0_lo", bus.lo, 32'hFFFF_FFFF);
        chk("divu_by0_hi", bus.hi, 32'h0000_0005);

        // Dependent MFLO presented in the fifth busy cycle
        present(4'd2, 32'h1234_5678, 32'd9);
        idle(4);
        bus.op = 4'd8;
        #1;
        stalls = 0;
        while (bus.stall_req === 1'b1 && stalls < 100) begin
            @(posedge clk);
            @(negedge clk);
            #1;
            stalls++;
        end
        chk("mflo_stall_cycles", stalls, 32'd29);
        chk("mflo_new_lo", bus.rdata, 32'hA3D7_0A38);
        chk("mflo_done_same_cycle", 32'(bus.done), 32'd1);
        idle(1);
        bus.op = 4'd0;

        // A second MULT is held until the first completes
        present(4'd1, 32'd3, 32'd5);
        present(4'd1, 32'hFFFF_FFFF, 32'd6);
        wait_done();
        chk("b2b_hi", bus.hi, 32'hFFFF_FFFF);
        chk("b2b_lo", bus.lo, 32'hFFFF_FFFA);

        // MTHI/MTLO followed by MFHI/MFLO
        present(4'd5, 32'h1234_5678, 32'd0);
        bus.op = 4'd7;
        #1;
        chk("mfhi_after_mthi", bus.rdata, 32'h1234_5678);
        present(4'd6, 32'hCAFE_F00D, 32'd0);
        bus.op = 4'd8;
        #1;
        chk("mflo_after_mtlo", bus.rdata, 32'hCAFE_F00D);
        bus.op = 4'd0;

        // kill in IDLE suppresses an MT write
        bus.op   = 4'd5;
        bus.a    = 32'hDEAD_BEEF;
        bus.kill = 1'b1;
        idle(1);
        bus.kill = 1'b0;
        bus.op   = 4'd0;
        chk("kill_idle_hi", bus.hi, 32'h1234_5678);

        // kill in the tenth busy cycle of a DIV
        present(4'd4, 32'd1000, 32'd3);
        idle(9);
        bus.kill = 1'b1;
        idle(1);
        bus.kill = 1'b0;
        chk("kill_busy", 32'(bus.busy), 32'd0);
        seen = 1'b0;
        repeat (40) begin
            idle(1);
            if (bus.done === 1'b1) seen = 1'b1;
        end
        chk("kill_no_done", 32'(seen), 32'd0);
        chk("kill_hi", bus.hi, 32'h1234_5678);
        chk("kill_lo", bus.lo, 32'hCAFE_F00D);

        // kill coinciding with the last iteration edge
        present(4'd2, 32'd11, 32'd13);
        idle(31);
        bus.kill = 1'b1;
        idle(1);
        bus.kill = 1'b0;
        chk("kill_last_busy", 32'(bus.busy), 32'd0);
        idle(2);
        chk("kill_last_lo", bus.lo, 32'hCAFE_F00D);

        // Asynchronous reset in the middle of CALC
        present(4'd1, 32'd9, 32'd9);
        idle(10);
        bus.op = 4'd8;
        #2;
        reset = 1'b0;
        #1;
        chk("midrst_busy", 32'(bus.busy), 32'd0);
        chk("midrst_stall", 32'(bus.stall_req), 32'd0);
        chk("midrst_done", 32'(bus.done), 32'd0);
        chk("midrst_hi", bus.hi, 32'd0);
        chk("midrst_lo", bus.lo, 32'd0);
        chk("midrst_rdata", bus.rdata, 32'd0);
        @(negedge clk);
        #1;
        reset  = 1'b1;
        bus.op = 4'd0;
        idle(1);
        present(4'd1, 32'd3, 32'd4);
        wait_done();
        chk("post_rst_lo", bus.lo, 32'd12);
        chk("post_rst_hi", bus.hi, 32'd0);

        // Random op stream, with kills sprinkled in
        for (int i = 0; i < 60; i++) begin
            o = ($urandom_range(0, 9) < 7) ? 4'($urandom_range(1, 8)) : 4'($urandom_range(0, 15));
            x = pick_operand();
            y = pick_operand();
            present(o, x, y);
            k = $urandom_range(0, 9);
            if (k == 0) begin
                idle($urandom_range(0, 40));
                bus.kill = 1'b1;
                idle(1);
                bus.kill = 1'b0;
            end else if (k < 4) begin
                idle($urandom_range(0, 40));
            end
        end
        idle(40);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
